// File: rtl/alu_resbuf_pkg.sv
// ============================================================================
//  alu_resbuf_pkg
//  Shared flag bit positions, entry layout and flag packing helper.
//  Rev 1.0
// ============================================================================
`default_nettype none

package alu_resbuf_pkg;

   localparam int FLAGS_W   = 4;
   localparam int FLG_CARRY = 3;
   localparam int FLG_ZERO  = 2;
   localparam int FLG_OVF   = 1;
   localparam int FLG_SIGN  = 0;

   localparam int RES_W     = 128;
   localparam int TAG_BITS  = 4;

   typedef struct packed {
      logic [RES_W-1:0]    result;
      logic [FLAGS_W-1:0]  flags;
      logic [TAG_BITS-1:0] tag;
   } resbuf_entry_t;

   function automatic logic [FLAGS_W-1:0] pack_flags(
      input logic carry,
      input logic zero,
      input logic ovf,
      input logic sign
   );
      logic [FLAGS_W-1:0] f;
      f            = '0;
      f[FLG_CARRY] = carry;
      f[FLG_ZERO]  = zero;
      f[FLG_OVF]   = ovf;
      f[FLG_SIGN]  = sign;
      return f;
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_resbuf_fifo.sv
// ============================================================================
//  alu_resbuf_fifo
//  Synchronous DEPTH-entry FIFO with push/pop/flush and occupancy outputs.
//  Rev 1.0
// ============================================================================
`default_nettype none

module alu_resbuf_fifo #(
   parameter int DEPTH   = 4,
   parameter int ENTRY_W = 136
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [ENTRY_W-1:0]       wr_data,
   output logic [ENTRY_W-1:0]       rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [ENTRY_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               push_ok;
   logic               pop_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   // A push into a full FIFO is dropped; the caller flags it.
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_result_buffer.sv
// ============================================================================
//  alu_result_buffer
//  Tags ALU ops through the fixed ALU latency, buffers results in a FIFO and
//  throttles the issuer with credits. ALU_RESBUF_OVF_CNT_EN adds ovf_count.
//  Rev 1.0
// ============================================================================
`default_nettype none

module alu_result_buffer
   import alu_resbuf_pkg::*;
#(
   parameter int WIDTH   = 128,
   parameter int LATENCY = 2,
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 issue_valid,
   input  logic [TAG_W-1:0]     issue_tag,
   output logic                 issue_ready,
   input  logic                 flush,
   input  logic [WIDTH-1:0]     alu_result,
   input  logic                 alu_carry,
   input  logic                 alu_zero,
   input  logic                 alu_ovf,
   input  logic                 alu_sign,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_result,
   output logic [FLAGS_W-1:0]   out_flags,
   output logic [TAG_W-1:0]     out_tag,
`ifdef ALU_RESBUF_OVF_CNT_EN
   output logic [15:0]          ovf_count,
`endif
   output logic                 err
);

   localparam int CNT_W   = $clog2(DEPTH) + 1;
   localparam int ENTRY_W = WIDTH + FLAGS_W + TAG_W;

   logic [LATENCY-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q [LATENCY];
   logic [TAG_W-1:0]   tag_d [LATENCY];
   logic               ready_en_q, ready_en_d;
   logic               err_q, err_d;

   logic               accept;
   logic               push;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;
   logic [31:0]        inflight;
   logic [ENTRY_W-1:0] wr_data;
   logic [ENTRY_W-1:0] rd_data;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LATENCY; i++) begin
         inflight = inflight + 32'(valid_q[i]);
      end
   end

   // Every in-flight op already owns a FIFO slot, so no capture can be lost.
   assign issue_ready = ready_en_q & ~flush &
                        ((32'(fifo_count) + inflight) < 32'(DEPTH));
   assign accept      = issue_valid & issue_ready;

   assign push    = valid_q[LATENCY-1];
   assign pop     = ~fifo_empty & out_ready & ~flush;
   assign wr_data = {alu_result,
                     pack_flags(alu_carry, alu_zero, alu_ovf, alu_sign),
                     tag_q[LATENCY-1]};

   always_comb begin
      valid_d = '0;
      for (int i = 0; i < LATENCY; i++) begin
         tag_d[i] = '0;
      end
      if (!flush) begin
         valid_d[0] = accept;
         tag_d[0]   = issue_tag;
         for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            tag_d[i]   = tag_q[i-1];
         end
      end
      ready_en_d = 1'b1;
      err_d      = err_q | (push & fifo_full & ~flush);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q    <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            tag_q[i] <= '0;
         end
         ready_en_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         tag_q      <= tag_d;
         ready_en_q <= ready_en_d;
         err_q      <= err_d;
      end
   end

   alu_resbuf_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .flush   (flush),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign out_valid  = ~fifo_empty;
   assign out_result = rd_data[ENTRY_W-1 -: WIDTH];
   assign out_flags  = rd_data[TAG_W +: FLAGS_W];
   assign out_tag    = rd_data[TAG_W-1:0];
   assign err        = err_q;

`ifdef ALU_RESBUF_OVF_CNT_EN
   logic [15:0] ovf_count_q, ovf_count_d;

   // Saturating; only reset clears it, flush leaves it alone.
   always_comb begin
      ovf_count_d = ovf_count_q;
      if (pop && out_flags[FLG_OVF] && (ovf_count_q != 16'hFFFF)) begin
         ovf_count_d = ovf_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ovf_count_q <= '0;
      end else begin
         ovf_count_q <= ovf_count_d;
      end
   end

   assign ovf_count = ovf_count_q;
`endif

endmodule

`default_nettype wire
